axi_master_arbiter: RTL and testbench

- Multiplexes NUM_MASTERS upstream AXI4 master ports (one per compute-core MCU) onto the single AXI4 data-memory master port of the multi-core gpu top.
- Write and read paths are arbitrated independently, each with its own round-robin pointer.
- Each path allows one outstanding transaction, and bursts are supported.
- The downstream ID carries the master index, so the memory system can distinguish cores.

---
 rtl/axi_master_arbiter_pkg.sv | 46 ++++
 rtl/axi_master_arbiter_rr_arbiter.sv | 39 +++
 rtl/axi_master_arbiter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arbiter_pkg
// Description : Shared AXI encodings, arbiter FSM state types and default
//               widths for the multi-master AXI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_master_arbiter_pkg;

    localparam int c_DEF_ADDR_WIDTH = 32;
    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_ID_WIDTH   = 1;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Index width for n masters; a single master still needs a 1-bit field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_master_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requester at or after
//               ptr, wrapping to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    // Two passes: indices >= ptr first, then the wrapped-around lower ones.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_req && req[j] && (IDX_W'(j) >= ptr)) begin
                any_req = 1'b1;
                grant   = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                grant   = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arbiter
// Description : Multiplexes NUM_MASTERS AXI4 masters onto one downstream
//               port. Independent round-robin write and read paths, one
//               outstanding burst each; grant index prefixed onto the ID.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int ID_WIDTH    = c_DEF_ID_WIDTH,
    localparam int IDX_W      = idx_width(NUM_MASTERS),
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int MID_W      = ID_WIDTH + IDX_W
) (
    input  logic                            clk,
    input  logic                            reset,
    // upstream write address
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_awid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [NUM_MASTERS*8-1:0]          s_axi_awlen,
    input  logic [NUM_MASTERS*3-1:0]          s_axi_awsize,
    input  logic [NUM_MASTERS*2-1:0]          s_axi_awburst,
    input  logic [NUM_MASTERS-1:0]            s_axi_awvalid,
    output logic [NUM_MASTERS-1:0]            s_axi_awready,
    // upstream write data / response
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0]     s_axi_wstrb,
    input  logic [NUM_MASTERS-1:0]            s_axi_wlast,
    input  logic [NUM_MASTERS-1:0]            s_axi_wvalid,
    output logic [NUM_MASTERS-1:0]            s_axi_wready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_bid,
    output logic [NUM_MASTERS*2-1:0]          s_axi_bresp,
    output logic [NUM_MASTERS-1:0]            s_axi_bvalid,
    input  logic [NUM_MASTERS-1:0]            s_axi_bready,
    // upstream read address / data
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_MASTERS*8-1:0]          s_axi_arlen,
    input  logic [NUM_MASTERS*3-1:0]          s_axi_arsize,
    input  logic [NUM_MASTERS*2-1:0]          s_axi_arburst,
    input  logic [NUM_MASTERS-1:0]            s_axi_arvalid,
    output logic [NUM_MASTERS-1:0]            s_axi_arready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_rid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [NUM_MASTERS*2-1:0]          s_axi_rresp,
    output logic [NUM_MASTERS-1:0]            s_axi_rlast,
    output logic [NUM_MASTERS-1:0]            s_axi_rvalid,
    input  logic [NUM_MASTERS-1:0]            s_axi_rready,
    // downstream write
    output logic [MID_W-1:0]      m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_W-1:0]     m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [MID_W-1:0]      m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // downstream read
    output logic [MID_W-1:0]      m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [MID_W-1:0]      m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] w_wr_pick, w_rd_pick;
    logic             w_wr_any, w_rd_any;

    // Per-master views of the packed upstream buses.
    logic [ID_WIDTH-1:0]   w_awid   [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] w_awaddr [NUM_MASTERS];
    logic [7:0]            w_awlen  [NUM_MASTERS];
    logic [2:0]            w_awsize [NUM_MASTERS];
    logic [1:0]            w_awburst[NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_wdata  [NUM_MASTERS];
    logic [STRB_W-1:0]     w_wstrb  [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   w_arid   [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] w_araddr [NUM_MASTERS];
    logic [7:0]            w_arlen  [NUM_MASTERS];
    logic [2:0]            w_arsize [NUM_MASTERS];
    logic [1:0]            w_arburst[NUM_MASTERS];

    // Downstream ID index bits are not needed for routing (grant is used).
    logic w_unused_idx;
    assign w_unused_idx = ^{m_axi_bid[MID_W-1:ID_WIDTH], m_axi_rid[MID_W-1:ID_WIDTH]};

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
            assign w_awid[i]    = s_axi_awid   [i*ID_WIDTH   +: ID_WIDTH];
            assign w_awaddr[i]  = s_axi_awaddr [i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_awlen[i]   = s_axi_awlen  [i*8          +: 8];
            assign w_awsize[i]  = s_axi_awsize [i*3          +: 3];
            assign w_awburst[i] = s_axi_awburst[i*2          +: 2];
            assign w_wdata[i]   = s_axi_wdata  [i*DATA_WIDTH +: DATA_WIDTH];
            assign w_wstrb[i]   = s_axi_wstrb  [i*STRB_W     +: STRB_W];
            assign w_arid[i]    = s_axi_arid   [i*ID_WIDTH   +: ID_WIDTH];
            assign w_araddr[i]  = s_axi_araddr [i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_arlen[i]   = s_axi_arlen  [i*8          +: 8];
            assign w_arsize[i]  = s_axi_arsize [i*3          +: 3];
            assign w_arburst[i] = s_axi_arburst[i*2          +: 2];
        end
    endgenerate

    rr_arbiter #(.N(NUM_MASTERS)) u_wr_arb (
        .req    (s_axi_awvalid),
        .ptr    (wr_ptr_q),
        .grant  (w_wr_pick),
        .any_req(w_wr_any)
    );

    rr_arbiter #(.N(NUM_MASTERS)) u_rd_arb (
        .req    (s_axi_arvalid),
        .ptr    (rd_ptr_q),
        .grant  (w_rd_pick),
        .any_req(w_rd_any)
    );

    // State, grant and round-robin pointer registers for both paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wr_grant_q <= '0;
            wr_ptr_q   <= '0;
            rd_state_q <= R_IDLE;
            rd_grant_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Write path: arbitrate in IDLE, then pass AW, W and B for the grantee.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_grant_d    = wr_grant_q;
        wr_ptr_d      = wr_ptr_q;
        m_axi_awid    = '0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_awsize  = '0;
        m_axi_awburst = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (w_wr_any) begin
                    wr_grant_d = w_wr_pick;
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                m_axi_awid    = {wr_grant_q, w_awid[wr_grant_q]};
                m_axi_awaddr  = w_awaddr[wr_grant_q];
                m_axi_awlen   = w_awlen[wr_grant_q];
                m_axi_awsize  = w_awsize[wr_grant_q];
                m_axi_awburst = w_awburst[wr_grant_q];
                m_axi_awvalid = s_axi_awvalid[wr_grant_q];
                if (s_axi_awvalid[wr_grant_q] && m_axi_awready) begin
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                m_axi_wdata  = w_wdata[wr_grant_q];
                m_axi_wstrb  = w_wstrb[wr_grant_q];
                m_axi_wlast  = s_axi_wlast[wr_grant_q];
                m_axi_wvalid = s_axi_wvalid[wr_grant_q];
                if (s_axi_wvalid[wr_grant_q] && m_axi_wready && s_axi_wlast[wr_grant_q]) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                m_axi_bready = s_axi_bready[wr_grant_q];
                if (m_axi_bvalid && s_axi_bready[wr_grant_q]) begin
                    wr_ptr_d   = (wr_grant_q == c_LAST_IDX) ? '0 : wr_grant_q + 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path: arbitrate in IDLE, pass AR, then route R beats until rlast.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_grant_d    = rd_grant_q;
        rd_ptr_d      = rd_ptr_q;
        m_axi_arid    = '0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_arburst = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (w_rd_any) begin
                    rd_grant_d = w_rd_pick;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axi_arid    = {rd_grant_q, w_arid[rd_grant_q]};
                m_axi_araddr  = w_araddr[rd_grant_q];
                m_axi_arlen   = w_arlen[rd_grant_q];
                m_axi_arsize  = w_arsize[rd_grant_q];
                m_axi_arburst = w_arburst[rd_grant_q];
                m_axi_arvalid = s_axi_arvalid[rd_grant_q];
                if (s_axi_arvalid[rd_grant_q] && m_axi_arready) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                m_axi_rready = s_axi_rready[rd_grant_q];
                if (m_axi_rvalid && s_axi_rready[rd_grant_q] && m_axi_rlast) begin
                    rd_ptr_d   = (rd_grant_q == c_LAST_IDX) ? '0 : rd_grant_q + 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Upstream fan-out: only the granted master in the matching state sees
    // anything other than zero.
    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_fanout
            logic w_aw_sel, w_w_sel, w_b_sel, w_ar_sel, w_r_sel;
            assign w_aw_sel = (wr_state_q == W_ADDR) && (wr_grant_q == IDX_W'(i));
            assign w_w_sel  = (wr_state_q == W_DATA) && (wr_grant_q == IDX_W'(i));
            assign w_b_sel  = (wr_state_q == W_RESP) && (wr_grant_q == IDX_W'(i));
            assign w_ar_sel = (rd_state_q == R_ADDR) && (rd_grant_q == IDX_W'(i));
            assign w_r_sel  = (rd_state_q == R_DATA) && (rd_grant_q == IDX_W'(i));

            assign s_axi_awready[i] = w_aw_sel & m_axi_awready;
            assign s_axi_wready[i]  = w_w_sel & m_axi_wready;
            assign s_axi_bvalid[i]  = w_b_sel & m_axi_bvalid;
            assign s_axi_bid  [i*ID_WIDTH +: ID_WIDTH] = w_b_sel ? m_axi_bid[ID_WIDTH-1:0] : '0;
            assign s_axi_bresp[i*2        +: 2]        = w_b_sel ? m_axi_bresp : '0;

            assign s_axi_arready[i] = w_ar_sel & m_axi_arready;
            assign s_axi_rvalid[i]  = w_r_sel & m_axi_rvalid;
            assign s_axi_rlast[i]   = w_r_sel & m_axi_rlast;
            assign s_axi_rid  [i*ID_WIDTH   +: ID_WIDTH]   = w_r_sel ? m_axi_rid[ID_WIDTH-1:0] : '0;
            assign s_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_r_sel ? m_axi_rdata : '0;
            assign s_axi_rresp[i*2          +: 2]          = w_r_sel ? m_axi_rresp : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_master_arbiter
// Description : Directed self-checking bench for axi_master_arbiter with two
//               masters; the bench plays the downstream memory by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_arbiter;
    import axi_master_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic reset;

    logic [N*IW-1:0] s_awid, s_arid, s_bid, s_rid;
    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*8-1:0]  s_awlen, s_arlen;
    logic [N*3-1:0]  s_awsize, s_arsize;
    logic [N*2-1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [N-1:0]    s_awvalid, s_awready, s_arvalid, s_arready;
    logic [N*DW-1:0] s_wdata, s_rdata;
    logic [N*4-1:0]  s_wstrb;
    logic [N-1:0]    s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0]    s_rlast, s_rvalid, s_rready;

    logic [MW-1:0] m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [7:0]    m_awlen, m_arlen;
    logic [2:0]    m_awsize, m_arsize;
    logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
    logic          m_awvalid, m_awready, m_arvalid, m_arready;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic          m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_rlast, m_rvalid, m_rready;

    int n_cmp = 0;
    int n_err = 0;
    int wb, rb, g, wt;
    int beats [N];

    axi_master_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
        .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst),
        .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
        .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst),
        .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = '0;
        s_rready = '0;
        m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
        beats[0] = 0; beats[1] = 0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_m_bready", m_bready, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s_readies", {s_awready, s_arready, s_wready}, 0);
        chk("rst_s_valids", {s_bvalid, s_rvalid}, 0);
        chk("rst_m_wdata", m_wdata, 0);
        step();
        reset = 1'b0;

        // ---- single write from master 1 ----
        s_awid = 2'b10; s_awaddr = {32'h40, 32'h0}; s_awlen = '0;
        s_awsize = {3'd2, 3'd0}; s_awburst = {2'(AXI_BURST_INCR), 2'b00}; s_awvalid = 2'b10;
        @(negedge clk);
        chk("w1_aw_latency", m_awvalid, 0);
        step();
        @(negedge clk);
        chk("w1_awvalid", m_awvalid, 1);
        chk("w1_awid", m_awid, 2'b11);
        chk("w1_awaddr", m_awaddr, 32'h40);
        chk("w1_awlen", m_awlen, 0);
        chk("w1_awready_wait", s_awready, 0);
        chk("w1_bready_idle", m_bready, 0);
        m_awready = 1;
        #1;
        chk("w1_awready_route", s_awready, 2'b10);
        step();
        s_awvalid = 0; m_awready = 0;
        s_wdata = {32'hDEADBEEF, 32'h0}; s_wstrb = 8'hF0; s_wlast = 2'b10; s_wvalid = 2'b10; m_wready = 1;
        @(negedge clk);
        chk("w1_wvalid", m_wvalid, 1);
        chk("w1_wdata", m_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", m_wstrb, 4'hF);
        chk("w1_wlast", m_wlast, 1);
        chk("w1_wready_route", s_wready, 2'b10);
        step();
        s_wvalid = 0; s_wlast = 0; m_wready = 0;
        m_bvalid = 1; m_bid = 2'b11; m_bresp = 2'(AXI_RESP_OKAY); s_bready = 2'b11;
        @(negedge clk);
        chk("w1_bvalid_route", s_bvalid, 2'b10);
        chk("w1_bid_strip", s_bid, 2'b10);
        chk("w1_bresp", s_bresp, 0);
        chk("w1_bready", m_bready, 1);
        step();
        m_bvalid = 0; m_bid = '0;
        @(negedge clk);
        chk("w1_b_done", {s_bvalid, m_bready}, 0);
        step();

        // ---- back-to-back reads from both masters, arlen=3 ----
        s_arid = 2'b10; s_araddr = {32'h200, 32'h100}; s_arlen = {8'd3, 8'd3};
        s_arsize = {3'd2, 3'd2}; s_arburst = {2'(AXI_BURST_INCR), 2'(AXI_BURST_INCR)};
        s_arvalid = 2'b11; s_rready = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = t % 2;
            wt = 0;
            @(negedge clk);
            while (!m_arvalid && wt < 8) begin
                @(negedge clk);
                wt++;
            end
            chk("rd_ar_seen", m_arvalid, 1);
            chk("rd_grant_arid", m_arid, (g == 1) ? 2'b11 : 2'b00);
            chk("rd_araddr", m_araddr, (g == 1) ? 32'h200 : 32'h100);
            m_arready = 1;
            step();
            m_arready = 0;
            for (int b = 0; b < 4; b++) begin
                if (t == 3 && b == 2) begin
                    m_rvalid = 0;
                    @(negedge clk);
                    chk("rd_gap_rvalid", s_rvalid, 0);
                    chk("rd_gap_hold", m_rready, 1);
                    step();
                end
                m_rvalid = 1; m_rid = (g == 1) ? 2'b11 : 2'b00;
                m_rdata = 32'hC000_0000 + 32'(t * 16 + b); m_rlast = (b == 3);
                @(negedge clk);
                chk("rd_rvalid_route", s_rvalid, (g == 1) ? 2'b10 : 2'b01);
                chk("rd_rdata", s_rdata, (g == 1) ? {32'hC000_0000 + 32'(t * 16 + b), 32'h0}
                                                  : {32'h0, 32'hC000_0000 + 32'(t * 16 + b)});
                chk("rd_rid_strip", s_rid, (g == 1) ? 2'b10 : 2'b00);
                chk("rd_rlast", s_rlast, (b == 3) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00);
                if (s_rvalid != 0) beats[g] = beats[g] + 1;
                step();
            end
            m_rvalid = 0; m_rlast = 0;
        end
        s_arvalid = 0;
        chk("rd_beats_m0", beats[0], 8);
        chk("rd_beats_m1", beats[1], 8);
        step();
        step();

        // ---- write burst (m0, 8 beats) concurrent with read (m1), throttled ----
        s_awid = 2'b00; s_awaddr = {32'h0, 32'h1000}; s_awlen = {8'd0, 8'd7}; s_awvalid = 2'b01;
        s_arid = 2'b10; s_araddr = {32'h300, 32'h0}; s_arlen = {8'd3, 8'd0}; s_arvalid = 2'b10;
        @(negedge clk);
        chk("cc_latency", {m_awvalid, m_arvalid}, 0);
        step();
        @(negedge clk);
        chk("cc_awid", m_awid, 2'b00);
        chk("cc_awlen", m_awlen, 7);
        chk("cc_arid", m_arid, 2'b11);
        chk("cc_araddr", m_araddr, 32'h300);
        m_awready = 1; m_arready = 1;
        step();
        s_awvalid = 0; s_arvalid = 0; m_awready = 0; m_arready = 0;
        wb = 0; rb = 0;
        for (int cyc = 0; cyc < 40 && (wb < 8 || rb < 4); cyc++) begin
            s_wvalid = (wb < 8) ? 2'b01 : 2'b00;
            s_wdata = {32'h0, 32'hA000_0000 + 32'(wb)};
            s_wstrb = 8'h0F;
            s_wlast = (wb == 7) ? 2'b01 : 2'b00;
            m_wready = (cyc % 2 == 0);
            m_rvalid = (rb < 4) && (cyc % 3 != 2);
            m_rdata = 32'hB000_0000 + 32'(rb);
            m_rid = 2'b11;
            m_rlast = (rb == 3);
            @(negedge clk);
            chk("cc_wvalid", m_wvalid, (wb < 8));
            if (wb < 8) chk("cc_wdata", m_wdata, 32'hA000_0000 + 32'(wb));
            chk("cc_wready_route", s_wready, {1'b0, m_wready && (wb < 8)});
            chk("cc_rvalid_route", s_rvalid, {m_rvalid, 1'b0});
            chk("cc_rready_hold", m_rready, (rb < 4));
            if (m_rvalid) chk("cc_rdata", s_rdata, {32'hB000_0000 + 32'(rb), 32'h0});
            chk("cc_no_b", s_bvalid, 0);
            if (wb < 8 && m_wready) wb++;
            if (m_rvalid) rb++;
            step();
        end
        s_wvalid = 0; s_wlast = 0; m_wready = 0; m_rvalid = 0; m_rlast = 0;
        chk("cc_wbeats", wb, 8);
        chk("cc_rbeats", rb, 4);
        m_bvalid = 1; m_bid = 2'b00; m_bresp = 2'(AXI_RESP_SLVERR); s_bready = 2'b01;
        @(negedge clk);
        chk("cc_bvalid_route", s_bvalid, 2'b01);
        chk("cc_bresp", s_bresp, 4'b0010);
        chk("cc_no_r", s_rvalid, 0);
        step();
        m_bvalid = 0; m_bresp = '0; s_bready = 2'b11;
        step();

        // ---- reset mid-burst after 3 of 8 beats ----
        s_awid = 2'b00; s_awaddr = {32'h0, 32'h80}; s_awlen = {8'd0, 8'd7}; s_awvalid = 2'b01;
        step();
        @(negedge clk);
        chk("rs_awvalid", m_awvalid, 1);
        chk("rs_awid", m_awid, 2'b00);
        m_awready = 1;
        step();
        s_awvalid = 0; m_awready = 0; m_wready = 1; s_wvalid = 2'b01; s_wlast = 0;
        for (int k = 0; k < 3; k++) begin
            s_wdata = {32'h0, 32'h5000_0000 + 32'(k)};
            @(negedge clk);
            chk("rs_wdata", m_wdata, 32'h5000_0000 + 32'(k));
            step();
        end
        chk("rs_pre_wvalid", m_wvalid, 1);
        reset = 1'b1;
        #1;
        chk("rs_wvalid", m_wvalid, 0);
        chk("rs_wready", s_wready, 0);
        chk("rs_wdata0", m_wdata, 0);
        chk("rs_others", {m_awvalid, m_arvalid, m_bready, m_rready, s_bvalid, s_rvalid}, 0);
        m_wready = 0; s_wvalid = 0; s_wdata = '0;
        step();
        reset = 1'b0;
        s_awid = 2'b10; s_awaddr = {32'h90, 32'h0}; s_awvalid = 2'b10;
        step();
        @(negedge clk);
        chk("rs_m1_grant", m_awid, 2'b11);
        chk("rs_m1_addr", m_awaddr, 32'h90);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_awid = 2'b10; s_awvalid = 2'b11;
        step();
        @(negedge clk);
        chk("rs_ptr_zero", m_awid, 2'b00);
        s_awvalid = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
